// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage sequencer between the execute stage and a byte-addressed,
// big-endian, combinational data RAM. It accepts one load/store per handshake
// and validates the width, alignment and address range. Legal requests are
// sequenced onto the RAM as SETUP (address/data settle) -> ACCESS (strobe) ->
// RESP. Faulting requests go straight to RESP without touching the RAM.
// Exactly one writeback response is returned per request.
//
// Parameters
//   MEM_BYTES  RAM size in bytes; an access touching any byte at or above it
//              faults as out-of-range.
//   ADDR_W     address width.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid/ready   request handshake from execute
//   req_store         1 = store, 0 = load
//   req_funct3        RISC-V width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr          effective byte address
//   req_wdata         store data (low bytes used for B/H)
//   req_rd            destination register
//   ram_addr          RAM address
//   ram_sel           {width[2:0], write}; 4'b1110 when idle
//   ram_wdata         RAM write data, right-aligned
//   ram_rdata         RAM read data, already sign/zero extended
//   wb_valid/ready    response handshake to writeback
//   wb_we, wb_rd      register write enable and destination
//   wb_data           load result (0 for stores and faults)
//   wb_err, wb_cause  fault flag; cause 01 misaligned, 10 out-of-range,
//                     11 illegal op
//
// Optional build macro
//   MEM_ACCESS_PERF_EN  adds saturating 32-bit counters cnt_load, cnt_store
//                       and cnt_fault, bumped on each completed response.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_err,
    output logic [1:0]        wb_cause
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]       cnt_load,
    output logic [31:0]       cnt_store,
    output logic [31:0]       cnt_fault
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam logic [3:0]    SEL_IDLE      = 4'b1110;
    localparam logic [1:0]    CAUSE_NONE    = 2'b00;
    localparam logic [1:0]    CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]    CAUSE_RANGE   = 2'b10;
    localparam logic [1:0]    CAUSE_ILLEGAL = 2'b11;
    localparam logic [ADDR_W:0] MEM_LIMIT   = (ADDR_W+1)'(MEM_BYTES);

    state_e              state_q, state_d;
    logic                store_q, store_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [4:0]          rd_q, rd_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic [3:0]          ram_sel_q, ram_sel_d;
    logic                wb_we_q, wb_we_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic                wb_err_q, wb_err_d;
    logic [1:0]          wb_cause_q, wb_cause_d;

    logic                accept;
    logic [1:0]          size_m1;
    logic [31:0]         wdata_aligned;
    logic                illegal;
    logic                misaligned;
    logic                out_of_range;
    logic [ADDR_W:0]     last_byte;
    logic [1:0]          req_cause;

    // A new request can be taken when idle, or while the current response is
    // being retired so back-to-back requests lose no cycle.
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && wb_ready);
    assign accept    = req_valid && req_ready;

    // Request classification, evaluated on the live request inputs so the
    // outcome is known at the accept edge.
    // NOTE: every combinational output gets a default before the case logic so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        size_m1       = 2'd3;
        wdata_aligned = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                size_m1       = 2'd0;
                wdata_aligned = {24'b0, req_wdata[7:0]};
            end
            2'b01: begin
                size_m1       = 2'd1;
                wdata_aligned = {16'b0, req_wdata[15:0]};
            end
            default: begin
                size_m1       = 2'd3;
                wdata_aligned = req_wdata;
            end
        endcase

        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_store && req_funct3[2]);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        // One extra bit so an access near the top of the address space cannot
        // wrap around and look in range.
        last_byte    = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, size_m1};
        out_of_range = (last_byte >= MEM_LIMIT);

        if (illegal) begin
            req_cause = CAUSE_ILLEGAL;
        end else if (misaligned) begin
            req_cause = CAUSE_MISALIGN;
        end else if (out_of_range) begin
            req_cause = CAUSE_RANGE;
        end else begin
            req_cause = CAUSE_NONE;
        end
    end

    // Next-state and datapath logic. ram_addr/ram_wdata only move on the accept
    // edge, where ram_sel is idle on both sides, so the RAM never sees an
    // address or data change while it is strobed.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_sel_d   = ram_sel_q;
        wb_we_d     = wb_we_q;
        wb_data_d   = wb_data_q;
        wb_err_d    = wb_err_q;
        wb_cause_d  = wb_cause_q;

        case (state_q)
            SETUP: begin
                ram_sel_d = {funct3_q, store_q};
                state_d   = ACCESS;
            end
            ACCESS: begin
                ram_sel_d = SEL_IDLE;
                if (store_q) begin
                    wb_data_d = 32'b0;
                    wb_we_d   = 1'b0;
                end else begin
                    wb_data_d = ram_rdata;
                    wb_we_d   = (rd_q != 5'd0);
                end
                state_d = RESP;
            end
            RESP: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Accept overrides the RESP retire path for back-to-back requests.
        if (accept) begin
            store_d    = req_store;
            funct3_d   = req_funct3;
            rd_d       = req_rd;
            wb_we_d    = 1'b0;
            wb_data_d  = 32'b0;
            wb_cause_d = req_cause;
            if (req_cause != CAUSE_NONE) begin
                wb_err_d = 1'b1;
                state_d  = RESP;
            end else begin
                wb_err_d    = 1'b0;
                ram_addr_d  = req_addr;
                ram_wdata_d = wdata_aligned;
                state_d     = SETUP;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'b0;
            rd_q        <= 5'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'b0;
            ram_sel_q   <= SEL_IDLE;
            wb_we_q     <= 1'b0;
            wb_data_q   <= 32'b0;
            wb_err_q    <= 1'b0;
            wb_cause_q  <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_sel_q   <= ram_sel_d;
            wb_we_q     <= wb_we_d;
            wb_data_q   <= wb_data_d;
            wb_err_q    <= wb_err_d;
            wb_cause_q  <= wb_cause_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_sel   = ram_sel_q;
    assign wb_valid  = (state_q == RESP);
    assign wb_we     = wb_we_q;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;
    assign wb_err    = wb_err_q;
    assign wb_cause  = wb_cause_q;

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] cnt_load_q, cnt_store_q, cnt_fault_q;
    logic        resp_done;

    // store_q/wb_err_q still describe the retiring request on this edge even
    // if a new request is accepted simultaneously.
    assign resp_done = (state_q == RESP) && wb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_load_q  <= 32'b0;
            cnt_store_q <= 32'b0;
            cnt_fault_q <= 32'b0;
        end else if (resp_done) begin
            if (wb_err_q) begin
                if (cnt_fault_q != 32'hFFFF_FFFF) cnt_fault_q <= cnt_fault_q + 32'd1;
            end else if (store_q) begin
                if (cnt_store_q != 32'hFFFF_FFFF) cnt_store_q <= cnt_store_q + 32'd1;
            end else begin
                if (cnt_load_q != 32'hFFFF_FFFF) cnt_load_q <= cnt_load_q + 32'd1;
            end
        end
    end

    assign cnt_load  = cnt_load_q;
    assign cnt_store = cnt_store_q;
    assign cnt_fault = cnt_fault_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A behavioural big-endian RAM sits on
// the ram_* side; a separate reference byte array plus rule-based
// classification predicts every response. Directed steps cover the documented
// scenarios, followed by randomized requests and a reset-abort step.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic [1:0]  wb_cause;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] cnt_load, cnt_store, cnt_fault;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_err    (wb_err),
        .wb_cause  (wb_cause)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .cnt_load  (cnt_load),
        .cnt_store (cnt_store),
        .cnt_fault (cnt_fault)
`endif
    );

    // ---------------- behavioural RAM (environment) ----------------
    logic [7:0]  ram_mem [0:MEM_BYTES-1];
    logic [11:0] ra0, ra1, ra2, ra3;
    assign ra0 = ram_addr[11:0];
    assign ra1 = ra0 + 12'd1;
    assign ra2 = ra0 + 12'd2;
    assign ra3 = ra0 + 12'd3;

    always_comb begin
        ram_rdata = 32'b0;
        case (ram_sel[3:1])
            3'b000:  ram_rdata = {{24{ram_mem[ra0][7]}}, ram_mem[ra0]};
            3'b100:  ram_rdata = {24'b0, ram_mem[ra0]};
            3'b001:  ram_rdata = {{16{ram_mem[ra0][7]}}, ram_mem[ra0], ram_mem[ra1]};
            3'b101:  ram_rdata = {16'b0, ram_mem[ra0], ram_mem[ra1]};
            3'b010:  ram_rdata = {ram_mem[ra0], ram_mem[ra1], ram_mem[ra2], ram_mem[ra3]};
            default: ram_rdata = 32'b0;
        endcase
    end

    always @(posedge clk) begin
        if (ram_sel[0]) begin
            case (ram_sel[3:1])
                3'b000: ram_mem[ra0] <= ram_wdata[7:0];
                3'b001: begin
                    ram_mem[ra0] <= ram_wdata[15:8];
                    ram_mem[ra1] <= ram_wdata[7:0];
                end
                3'b010: begin
                    ram_mem[ra0] <= ram_wdata[31:24];
                    ram_mem[ra1] <= ram_wdata[23:16];
                    ram_mem[ra2] <= ram_wdata[15:8];
                    ram_mem[ra3] <= ram_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] model_cause(input bit st, input logic [2:0] f3,
                                               input logic [31:0] a);
        longint addr;
        int     n;
        addr = a;
        n    = size_of(f3);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 2'b11;
        if (st && (f3 == 3'b100 || f3 == 3'b101)) return 2'b11;
        if ((addr % n) != 0) return 2'b01;
        if (addr + n - 1 >= MEM_BYTES) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          n;
        logic [31:0] v;
        n = size_of(f3);
        v = 32'b0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'b0, ref_mem[int'(a) + i]};
        if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        int n;
        n = size_of(f3);
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    // ---------------- checking ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] last_data;
    logic [41:0] snap;
    int          lat_bp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction starting from IDLE, with `hold` cycles of
    // writeback back-pressure before the response is taken.
    task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd, input int hold,
                           input string tag);
        logic [1:0]  cause;
        logic [31:0] exp_data;
        bit          legal;
        int          lat, sel_busy, wr_cyc;
        cause    = model_cause(st, f3, a);
        legal    = (cause == 2'b00);
        exp_data = (legal && !st) ? model_load(f3, a) : 32'b0;

        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        check({tag, " ready"}, req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        lat      = 1;
        sel_busy = 0;
        wr_cyc   = 0;
        forever begin
            if (ram_sel != 4'b1110) sel_busy++;
            if (ram_sel[0]) wr_cyc++;
            if (wb_valid || lat >= 8) break;
            @(negedge clk);
            lat++;
        end

        check({tag, " latency"}, lat, legal ? 3 : 1);
        check({tag, " wb_valid"}, wb_valid, 1'b1);
        check({tag, " wb_err"}, wb_err, !legal);
        check({tag, " wb_cause"}, wb_cause, cause);
        check({tag, " wb_we"}, wb_we, legal && !st && (rd != 5'd0));
        check({tag, " wb_data"}, wb_data, exp_data);
        if (legal) check({tag, " wb_rd"}, wb_rd, rd);
        check({tag, " sel_cycles"}, sel_busy, legal ? 1 : 0);
        check({tag, " write_cycles"}, wr_cyc, (legal && st) ? 1 : 0);
        check({tag, " busy"}, req_ready, 1'b0);
        last_data = wb_data;

        repeat (hold) @(negedge clk);
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        check({tag, " retired"}, wb_valid, 1'b0);
        if (legal && st) model_store(f3, a, wd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        for (int i = 0; i < MEM_BYTES; i++) begin
            b          = 8'($urandom());
            ram_mem[i] <= b;
            ref_mem[i] = b;
        end
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        req_rd     = 5'b0;
        wb_ready   = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        #1;
        check("rst req_ready", req_ready, 1'b1);
        check("rst wb_valid", wb_valid, 1'b0);
        check("rst wb_we", wb_we, 1'b0);
        check("rst wb_err", wb_err, 1'b0);
        check("rst wb_cause", wb_cause, 2'b00);
        check("rst wb_rd", wb_rd, 5'd0);
        check("rst wb_data", wb_data, 32'b0);
        check("rst ram_addr", ram_addr, 32'b0);
        check("rst ram_wdata", ram_wdata, 32'b0);
        check("rst ram_sel", ram_sel, 4'b1110);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        run_req(1'b1, 3'b010, 32'h100, 32'h1122_3344, 5'd0, 0, "sw_100");
        run_req(1'b0, 3'b000, 32'h101, 32'h0, 5'd1, 0, "lb_101");
        check("lb_101 value", last_data, 32'h0000_0022);
        run_req(1'b0, 3'b001, 32'h102, 32'h0, 5'd2, 1, "lh_102");
        check("lh_102 value", last_data, 32'h0000_3344);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 0, "lw_100");
        check("lw_100 value", last_data, 32'h1122_3344);
        run_req(1'b1, 3'b000, 32'h10, 32'hFFFF_FF80, 5'd0, 0, "sb_10");
        run_req(1'b0, 3'b000, 32'h10, 32'h0, 5'd4, 0, "lb_10");
        check("lb_10 value", last_data, 32'hFFFF_FF80);
        run_req(1'b0, 3'b100, 32'h10, 32'h0, 5'd5, 0, "lbu_10");
        check("lbu_10 value", last_data, 32'h0000_0080);
        run_req(1'b0, 3'b010, 32'h102, 32'h0, 5'd6, 0, "lw_misaligned");
        run_req(1'b0, 3'b001, 32'hFFF, 32'h0, 5'd6, 0, "lh_fff");
        run_req(1'b0, 3'b011, 32'h0, 32'h0, 5'd6, 0, "illegal_011");
        run_req(1'b1, 3'b100, 32'h0, 32'h0, 5'd6, 0, "store_bu");
        run_req(1'b1, 3'b001, 32'h3, 32'h0, 5'd6, 0, "sh_misaligned");
        run_req(1'b0, 3'b010, 32'hFFC, 32'h0, 5'd6, 0, "lw_ffc");
        run_req(1'b0, 3'b010, 32'h1000, 32'h0, 5'd6, 0, "lw_1000");
        run_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 5'd6, 0, "lw_wrap");
        run_req(1'b0, 3'b000, 32'hFFF, 32'h0, 5'd6, 0, "lb_fff");
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd0, 0, "lw_rd0");

        // Back-pressure, then a back-to-back accept on the retire edge
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_rd     = 5'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 8 && !wb_valid; i++) @(negedge clk);
        check("bp wb_valid", wb_valid, 1'b1);
        check("bp wb_data", wb_data, model_load(3'b010, 32'h100));
        snap       = {wb_valid, wb_we, wb_err, wb_cause, wb_rd, wb_data};
        req_valid  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h102;
        req_rd     = 5'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp stable", {wb_valid, wb_we, wb_err, wb_cause, wb_rd, wb_data}, snap);
            check("bp req_ready", req_ready, 1'b0);
        end
        wb_ready = 1'b1;
        #1;
        check("b2b req_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        wb_ready  = 1'b0;
        req_valid = 1'b0;
        check("b2b wb_valid_low", wb_valid, 1'b0);
        lat_bp = 1;
        while (!wb_valid && lat_bp < 8) begin
            @(negedge clk);
            lat_bp++;
        end
        check("b2b latency", lat_bp, 3);
        check("b2b wb_data", wb_data, model_load(3'b001, 32'h102));
        check("b2b wb_rd", wb_rd, 5'd9);
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        check("b2b retired", wb_valid, 1'b0);

        // Randomized requests
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            bit          st;
            case ($urandom_range(0, 3))
                0, 1:    a = $urandom_range(0, 63);
                2:       a = $urandom_range(4088, 4100);
                default: a = $urandom();
            endcase
            st = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(0, 2));
            run_req(st, f3, a, $urandom(), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2), "rnd");
        end

        // Reset asserted while a store is in ACCESS
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        req_wdata  = 32'hDEAD_BEEF;
        req_rd     = 5'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 8 && !ram_sel[0]; i++) @(negedge clk);
        check("abort in_access", ram_sel[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort ram_sel", ram_sel, 4'b1110);
        check("abort wb_valid", wb_valid, 1'b0);
        check("abort req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd11, 0, "lw_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
